// File: rtl/uart_sender_pkg.sv
// Shared definitions for the 8N1 UART transmitter: state encoding, default rates, frame shape.
package uart_sender_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_CLK_HZ = 50000000;
    localparam int unsigned DEFAULT_BAUD   = 9600;
    localparam int unsigned FRAME_BITS     = 10;
    localparam int unsigned DATA_BITS      = FRAME_BITS - 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while run is high, pulses tick on the last count.
module uart_baud_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] count;

    // Held at zero while idle so every frame starts on a fresh bit period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (!run || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = run && (count == CW'(DIV - 1));

endmodule

// File: rtl/uart_sender.sv
// 8N1 UART transmitter with a single-byte holding register in front of the shifter.
module uart_sender
    import uart_sender_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD   = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TX_DATA,
    input  logic       TX_EN,
    output logic       TX_STATUS,
    output logic       TX_BUSY,
    output logic       UART_TX
);

    localparam int unsigned DIV = CLK_HZ / BAUD;

    if (DIV < 4) begin : g_div_check
        $error("uart_sender: CLK_HZ/BAUD must be at least 4");
    end

    state_t     state, next_state;
    logic [2:0] bit_idx, next_idx;
    logic [7:0] shifter, next_shift;
    logic [7:0] hold;
    logic       hold_valid, next_hold_valid;
    logic       load;
    logic       accept;
    logic       tick;
    logic       tx_next;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .run   (state != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            bit_idx    <= 3'd0;
            hold_valid <= 1'b0;
            UART_TX    <= 1'b1;
            TX_BUSY    <= 1'b0;
        end else begin
            state      <= next_state;
            bit_idx    <= next_idx;
            hold_valid <= next_hold_valid;
            UART_TX    <= tx_next;
            TX_BUSY    <= (next_state != IDLE);
        end
    end

    // Data registers carry no reset; they are only observed once qualified.
    always_ff @(posedge clk) begin
        shifter <= next_shift;
        if (accept) begin
            hold <= TX_DATA;
        end
    end

    always_comb begin
        next_state      = state;
        next_idx        = bit_idx;
        next_shift      = shifter;
        next_hold_valid = hold_valid;
        load            = 1'b0;
        accept          = 1'b0;
        tx_next         = 1'b1;

        case (state)
            IDLE: begin
                if (hold_valid) begin
                    load       = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (tick) begin
                    next_state = DATA;
                    next_idx   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    next_shift = {1'b0, shifter[7:1]};
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        next_state = STOP;
                    end else begin
                        next_idx = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (hold_valid) begin
                        load       = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        // A transfer only happens with hold full, so a request is never accepted that cycle.
        if (load) begin
            next_shift      = hold;
            next_hold_valid = 1'b0;
        end else if (TX_EN && !hold_valid) begin
            accept          = 1'b1;
            next_hold_valid = 1'b1;
        end

        case (next_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = next_shift[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign TX_STATUS = ~hold_valid;

endmodule

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s; bit period DIV = CLK_HZ/BAUD cycles (integer division), DIV >= 4 SHALL hold, else elaboration error.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 TX_DATA  input  8  byte to transmit; sampled only in the accept cycle.
REQ-006 TX_EN  input  1  send request; a 1-cycle pulse suffices; level-held TX_EN SHALL be treated as one request per accept cycle.
REQ-007 TX_STATUS  output  1  high = holding register empty, request will be accepted.
REQ-008 TX_BUSY  output  1  high while a frame is on the line (state != IDLE).
REQ-009 UART_TX  output  1  serial line, registered, idle high.

Function
REQ-010 Frame SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly DIV cycles; frame = 10*DIV cycles.
REQ-011 Accept: TX_EN=1 while TX_STATUS=1 at edge n SHALL capture TX_DATA into hold, set hold_valid; TX_STATUS=0 from n+1.
REQ-012 TX_EN while TX_STATUS=0 SHALL be ignored: no state change, byte dropped.
REQ-013 FSM states IDLE, START, DATA, STOP; IDLE with hold_valid SHALL load shifter from hold, clear hold_valid, enter START next edge.
REQ-014 Latency: accept at edge n -> UART_TX=0 from n+2 (first START cycle); TX_STATUS=1 again from n+2.
REQ-015 Bit counter SHALL run 0..DIV-1 in every non-IDLE state; state/bit advance only when counter = DIV-1, counter then wraps to 0.
REQ-016 DATA SHALL use a 3-bit index 0..7; index 7 at counter DIV-1 -> STOP.
REQ-017 STOP end: if hold_valid, go directly to START (load hold, clear hold_valid), no idle gap; else IDLE.
REQ-018 A byte accepted while a frame is in progress SHALL wait in hold; only one byte is buffered.
REQ-019 Hold-to-shifter transfer and a TX_EN in the same cycle: TX_EN ignored (TX_STATUS=0 that cycle).
REQ-020 UART_TX SHALL be 1 in IDLE and STOP, 0 in START, shifter bit 0 in DATA; no glitches (driven from a flop).
REQ-021 TX_BUSY SHALL be 0 exactly in IDLE; TX_STATUS = ~hold_valid.

Reset
REQ-022 reset=0 at an edge SHALL force: state IDLE, counters 0, hold_valid 0, UART_TX 1, TX_STATUS 1, TX_BUSY 0, effective next cycle.
REQ-023 Reset mid-frame SHALL abandon the frame and discard hold; TX_EN during reset SHALL be ignored.
REQ-024 Shifter and hold data contents need not be reset.

Structure
REQ-025 Shared package SHALL hold state encoding (IDLE=0, START=1, DATA=2, STOP=3), default CLK_HZ and BAUD, and frame bit count 10.
REQ-026 Bit-period counter SHALL be sub-module uart_baud_tick (inputs clk, reset, run; output tick at count DIV-1; count restarts at 0 when run rises).
REQ-027 Remaining logic (FSM, hold, shifter) SHALL be in uart_sender; no latches, no combinational path from TX_EN to any output.

Verification (CLK_HZ=4, BAUD=1, so DIV=4)
REQ-028 Release reset, idle 20 cycles -> UART_TX=1, TX_STATUS=1, TX_BUSY=0 throughout.
REQ-029 TX_EN pulse with 0x55 at edge n -> UART_TX 0 for n+2..n+5, then 1,0,1,0,1,0,1,0 each 4 cycles, stop 1 for n+38..n+41, TX_BUSY=0 from n+42.
REQ-030 0xA3 at n, 0x0F at n+3 -> second accepted (TX_STATUS 0 from n+4), its start bit at n+42 with no gap; TX_STATUS=1 from n+42.
REQ-031 0x12 accepted at n, 0x34 at n+1 (TX_STATUS=0) -> only 0x12 transmitted, line idle after n+41.
REQ-032 reset=0 at n+15 during 0xFF frame -> UART_TX=1, TX_STATUS=1, TX_BUSY=0 from n+16; TX_EN with 0x81 held during reset produces no frame.
